// File: rtl/sarray_tinst_seq.sv
// Tile-instruction sequencer: queues whole matmul commands and expands each into
// PRELOADC -> PRELOADA -> TMMA -> POSTSTOREC on the single sarray issue port.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef TINST_TYPE_WIDTH
`define TINST_TYPE_WIDTH 3
`endif
`ifndef TINST_TYPE_PRELOADC
`define TINST_TYPE_PRELOADC 3'd1
`endif
`ifndef TINST_TYPE_PRELOADA
`define TINST_TYPE_PRELOADA 3'd2
`endif
`ifndef TINST_TYPE_TMMA
`define TINST_TYPE_TMMA 3'd3
`endif
`ifndef TINST_TYPE_POSTSTOREC
`define TINST_TYPE_POSTSTOREC 3'd4
`endif

module sarray_tinst_seq #(
    parameter int CMD_DEPTH = 4,
    parameter int CNT_WIDTH = $clog2(CMD_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [`ADDR_WIDTH-1:0]            cmd_c_addr_i,
    input  logic [`ADDR_WIDTH-1:0]            cmd_a_addr_i,
    input  logic [`ADDR_WIDTH-1:0]            cmd_b_addr_i,
    input  logic [`ADDR_WIDTH-1:0]            cmd_d_addr_i,
    input  logic [`TMMA_PRECISION_WIDTH-1:0]  cmd_precision_i,
    input  logic                              cmd_acc_i,
    input  logic                              cmd_skip_c_i,
    input  logic                              cmd_skip_store_i,
    output logic                              issue_tinst_valid_o,
    input  logic                              issue_tinst_ready_i,
    output logic [`TINST_TYPE_WIDTH-1:0]      issue_tinst_type_o,
    output logic [`ADDR_WIDTH-1:0]            issue_tinst_addr0_o,
    output logic [`ADDR_WIDTH-1:0]            issue_tinst_addr1_o,
    output logic [`TMMA_PRECISION_WIDTH-1:0]  issue_tinst_precision_o,
    output logic                              issue_tinst_acc_o,
    output logic                              cmd_done_o,
    output logic                              busy_o,
    output logic [CNT_WIDTH-1:0]              pending_cnt_o
);
    localparam int AW    = `ADDR_WIDTH;
    localparam int PW    = `TMMA_PRECISION_WIDTH;
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CMD_W = 4 * AW + PW + 3;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(CMD_DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S_PC  = 3'd1;
    localparam logic [2:0] S_PA  = 3'd2;
    localparam logic [2:0] S_MMA = 3'd3;
    localparam logic [2:0] S_ST  = 3'd4;

    logic [CMD_W-1:0]     fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [2:0]           state;
    logic [2:0]           next_state;
    logic                 done_q;

    logic [AW-1:0] cur_c, cur_a, cur_b, cur_d;
    logic [PW-1:0] cur_prec;
    logic          cur_acc;
    logic          cur_skip_store;

    logic [AW-1:0] head_c, head_a, head_b, head_d;
    logic [PW-1:0] head_prec;
    logic          head_acc, head_skip_c, head_skip_store;
    logic [2:0]    head_first;

    logic fifo_empty, fifo_full, in_flight;
    logic handshake, last_hs, pop, push;

    assign {head_c, head_a, head_b, head_d, head_prec,
            head_acc, head_skip_c, head_skip_store} = fifo_mem[rd_ptr];
    assign head_first = head_skip_c ? S_PA : S_PC;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign in_flight  = (state != IDLE);
    assign handshake  = in_flight & issue_tinst_ready_i;
    assign last_hs    = handshake & ((state == S_ST) | ((state == S_MMA) & cur_skip_store));
    assign pop        = !fifo_empty & ((state == IDLE) | last_hs);
    // A slot freed by this edge's pop may be refilled in the same edge.
    assign cmd_ready_o = !fifo_full | pop;
    assign push        = cmd_valid_i & cmd_ready_o;

    assign issue_tinst_valid_o = in_flight;
    assign cmd_done_o          = done_q;
    assign busy_o              = in_flight | !fifo_empty;
    assign pending_cnt_o       = count + {{(CNT_WIDTH-1){1'b0}}, in_flight};

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = head_first;
            S_PC:    if (handshake) next_state = S_PA;
            S_PA:    if (handshake) next_state = S_MMA;
            S_MMA: begin
                if (handshake) begin
                    if (!cur_skip_store) next_state = S_ST;
                    else                 next_state = pop ? head_first : IDLE;
                end
            end
            S_ST:    if (handshake) next_state = pop ? head_first : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        issue_tinst_type_o      = '0;
        issue_tinst_addr0_o     = '0;
        issue_tinst_addr1_o     = '0;
        issue_tinst_precision_o = '0;
        issue_tinst_acc_o       = 1'b0;
        case (state)
            S_PC: begin
                issue_tinst_type_o  = `TINST_TYPE_PRELOADC;
                issue_tinst_addr0_o = cur_c;
            end
            S_PA: begin
                issue_tinst_type_o  = `TINST_TYPE_PRELOADA;
                issue_tinst_addr0_o = cur_a;
            end
            S_MMA: begin
                issue_tinst_type_o      = `TINST_TYPE_TMMA;
                issue_tinst_addr0_o     = cur_b;
                issue_tinst_addr1_o     = cur_d;
                issue_tinst_precision_o = cur_prec;
                issue_tinst_acc_o       = cur_acc;
            end
            S_ST: begin
                issue_tinst_type_o  = `TINST_TYPE_POSTSTOREC;
                issue_tinst_addr0_o = cur_d;
            end
            default: ;
        endcase
    end

    // Storage carries no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_c_addr_i, cmd_a_addr_i, cmd_b_addr_i, cmd_d_addr_i,
                                 cmd_precision_i, cmd_acc_i, cmd_skip_c_i, cmd_skip_store_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            done_q         <= 1'b0;
            cur_c          <= '0;
            cur_a          <= '0;
            cur_b          <= '0;
            cur_d          <= '0;
            cur_prec       <= '0;
            cur_acc        <= 1'b0;
            cur_skip_store <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= last_hs;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                cur_c          <= head_c;
                cur_a          <= head_a;
                cur_b          <= head_b;
                cur_d          <= head_d;
                cur_prec       <= head_prec;
                cur_acc        <= head_acc;
                cur_skip_store <= head_skip_store;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
